// File: rtl/stopwatch_digits.sv
// ============================================================================
// Module      : stopwatch_digits
// Description : SS.cc stopwatch with IDLE/RUN/PAUSE control and a
//               multiplexed four-digit 7-segment scan output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_digits #(
    parameter int TICK_DIV = 1000000,
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] di,
    output logic [3:0] an,
    output logic       dp,
    output logic       running,
    output logic       wrap
);

    localparam int c_TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_TW-1:0] c_TICK_MAX = c_TW'(TICK_DIV - 1);
    localparam logic [c_SW-1:0] c_SCAN_MAX = c_SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t          r_state;
    logic [c_TW-1:0] r_tick;
    logic [c_SW-1:0] r_scan;
    logic [1:0]      r_sel;
    logic [3:0]      r_d0, r_d1, r_d2, r_d3;
    logic            r_wrap;

    logic w_tick;
    logic w_full;

    assign w_tick = (r_state == S_RUN) && (r_tick == c_TICK_MAX);
    assign w_full = (r_d3 == 4'd5) && (r_d2 == 4'd9) && (r_d1 == 4'd9) && (r_d0 == 4'd9);

    // Clear outranks start_stop; a pause request on a tick edge still counts that tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_d0    <= 4'd0;
            r_d1    <= 4'd0;
            r_d2    <= 4'd0;
            r_d3    <= 4'd0;
            r_wrap  <= 1'b0;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_d0    <= 4'd0;
            r_d1    <= 4'd0;
            r_d2    <= 4'd0;
            r_d3    <= 4'd0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (r_state == S_RUN) begin
                if (w_tick) begin
                    r_tick <= '0;
                    r_wrap <= w_full;
                    if (r_d0 == 4'd9) begin
                        r_d0 <= 4'd0;
                        if (r_d1 == 4'd9) begin
                            r_d1 <= 4'd0;
                            if (r_d2 == 4'd9) begin
                                r_d2 <= 4'd0;
                                r_d3 <= (r_d3 == 4'd5) ? 4'd0 : r_d3 + 4'd1;
                            end else begin
                                r_d2 <= r_d2 + 4'd1;
                            end
                        end else begin
                            r_d1 <= r_d1 + 4'd1;
                        end
                    end else begin
                        r_d0 <= r_d0 + 4'd1;
                    end
                end else begin
                    r_tick <= r_tick + 1'b1;
                end
            end
            if (start_stop) begin
                case (r_state)
                    S_IDLE:  r_state <= S_RUN;
                    S_RUN:   r_state <= S_PAUSE;
                    S_PAUSE: r_state <= S_RUN;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_sel  <= 2'd0;
        end else if (r_scan == c_SCAN_MAX) begin
            r_scan <= '0;
            r_sel  <= r_sel + 2'd1;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    always_comb begin
        an = 4'b1110;
        di = r_d0;
        case (r_sel)
            2'd0: begin an = 4'b1110; di = r_d0; end
            2'd1: begin an = 4'b1101; di = r_d1; end
            2'd2: begin an = 4'b1011; di = r_d2; end
            2'd3: begin an = 4'b0111; di = r_d3; end
            default: begin an = 4'b1110; di = r_d0; end
        endcase
    end

    assign dp      = (r_sel != 2'd2);
    assign running = (r_state == S_RUN);
    assign wrap    = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_digits.sv
// ============================================================================
// Module      : tb_stopwatch_digits
// Description : Directed bench for stopwatch_digits against a hundredths-count model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_digits;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSE  = 2;

    logic       clk;
    logic       rst_n;
    logic       start_stop;
    logic       clear;
    logic [3:0] di;
    logic [3:0] an;
    logic       dp;
    logic       running;
    logic       wrap;

    int n_pass  = 0;
    int n_total = 0;

    // Model: elapsed time as a plain hundredths count, scan as a cycle count.
    int   m_time;
    int   m_phase;
    int   m_st;
    int   m_cyc;
    logic m_wrap;

    stopwatch_digits #(
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .clear      (clear),
        .di         (di),
        .an         (an),
        .dp         (dp),
        .running    (running),
        .wrap       (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        int   t, ph, st;
        logic w;
        if (!rst_n) begin
            m_time  <= 0;
            m_phase <= 0;
            m_st    <= M_IDLE;
            m_wrap  <= 1'b0;
            m_cyc   <= 0;
        end else begin
            t  = m_time;
            ph = m_phase;
            st = m_st;
            w  = 1'b0;
            if (clear) begin
                t  = 0;
                ph = 0;
                st = M_IDLE;
            end else begin
                if (st == M_RUN) begin
                    if (ph == TICK_DIV - 1) begin
                        ph = 0;
                        t  = (t + 1) % 6000;
                        w  = (t == 0);
                    end else begin
                        ph = ph + 1;
                    end
                end
                if (start_stop) st = (st == M_RUN) ? M_PAUSE : M_RUN;
            end
            m_time  <= t;
            m_phase <= ph;
            m_st    <= st;
            m_wrap  <= w;
            m_cyc   <= (m_cyc + 1) % (4 * SCAN_DIV);
        end
    end

    always @(negedge clk) begin : compare
        int         sel;
        logic [3:0] e_di, e_an;
        logic       e_dp;
        sel = m_cyc / SCAN_DIV;
        case (sel)
            0:       e_di = 4'(m_time % 10);
            1:       e_di = 4'((m_time / 10) % 10);
            2:       e_di = 4'((m_time / 100) % 10);
            default: e_di = 4'(m_time / 1000);
        endcase
        e_an = ~(4'b0001 << sel);
        e_dp = (sel != 2);
        chk("cycle{an,di,dp,running,wrap}", {21'd0, an, di, dp, running, wrap},
            {21'd0, e_an, e_di, e_dp, (m_st == M_RUN), m_wrap});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ss();
        @(posedge clk); #1 start_stop = 1'b1;
        @(posedge clk); #1 start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] target, output bit found);
        logic [3:0] prev;
        found = 1'b0;
        prev  = an;
        for (int k = 0; k < 16 && !found; k++) begin
            step(1);
            if (an == target && prev != target) found = 1'b1;
            prev = an;
        end
    endtask

    logic [3:0] tbl_an [4];
    logic [3:0] tbl_di [4];
    logic       tbl_dp [4];

    initial begin
        bit found;
        tbl_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        tbl_di = '{4'd4, 4'd3, 4'd2, 4'd1};
        tbl_dp = '{1'b1, 1'b1, 1'b0, 1'b1};

        rst_n      = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_an", {28'd0, an}, 32'hE);
        chk("reset_di", {28'd0, di}, 32'h0);
        chk("reset_dp_run_wrap", {29'd0, dp, running, wrap}, 32'b100);
        step(3);
        rst_n = 1'b1;

        // Basic counting: 40 cycles of RUN is ten hundredths.
        pulse_ss();
        step(40);
        chk("count_time", m_time, 10);
        chk("count_running", {31'd0, running}, 1);

        // Pause two cycles after a tick, resume, next tick two cycles later.
        pulse_ss();
        step(20);
        chk("pause_time", m_time, 10);
        chk("pause_running", {31'd0, running}, 0);
        pulse_ss();
        step(1);
        chk("resume_plus1_time", m_time, 10);
        chk("resume_running", {31'd0, running}, 1);
        step(1);
        chk("resume_plus2_time", m_time, 11);

        // Pause request coinciding with the 1234th tick lands on 12.34.
        pulse_clear();
        chk("clear_time", m_time, 0);
        chk("clear_running", {31'd0, running}, 0);
        pulse_ss();
        step(4934);
        pulse_ss();
        chk("tick_pause_time", m_time, 1234);
        chk("tick_pause_running", {31'd0, running}, 0);

        wait_an(4'b1110, found);
        chk("scan_sync", {31'd0, found}, 1);
        for (int s = 0; s < 4; s++) begin
            for (int h = 0; h < 2; h++) begin
                chk("scan_an", {28'd0, an}, {28'd0, tbl_an[s]});
                chk("scan_di", {28'd0, di}, {28'd0, tbl_di[s]});
                chk("scan_dp", {31'd0, dp}, {31'd0, tbl_dp[s]});
                step(1);
            end
        end

        // Clear and start_stop together while running: clear wins.
        pulse_ss();
        step(10);
        chk("prio_pre_running", {31'd0, running}, 1);
        @(posedge clk); #1 begin clear = 1'b1; start_stop = 1'b1; end
        @(posedge clk); #1 begin clear = 1'b0; start_stop = 1'b0; end
        chk("prio_running", {31'd0, running}, 0);
        chk("prio_time", m_time, 0);
        step(8);
        chk("prio_idle_running", {31'd0, running}, 0);

        // Rollover 59.99 -> 00.00.
        pulse_ss();
        step(23996);
        chk("roll_pre_time", m_time, 5999);
        chk("roll_pre_wrap", {31'd0, wrap}, 0);
        step(4);
        chk("roll_time", m_time, 0);
        chk("roll_wrap", {31'd0, wrap}, 1);
        chk("roll_running", {31'd0, running}, 1);
        step(1);
        chk("roll_wrap_drop", {31'd0, wrap}, 0);

        // Asynchronous reset mid-cycle while running on a nonzero digit.
        step(44);
        wait_an(4'b1101, found);
        chk("areset_sync", {31'd0, found}, 1);
        chk("areset_pre_di", {28'd0, di}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("areset_an", {28'd0, an}, 32'hE);
        chk("areset_di", {28'd0, di}, 32'h0);
        chk("areset_dp_run_wrap", {29'd0, dp, running, wrap}, 32'b100);
        @(posedge clk); #1 rst_n = 1'b1;
        step(10);
        chk("post_reset_running", {31'd0, running}, 0);
        chk("post_reset_time", m_time, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stopwatch_digits.md
STOPWATCH_DIGITS -- requirements
Module: stopwatch_digits

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, clock cycles per 10 ms count tick (100 MHz clk).
REQ-002 SHALL have parameter SCAN_DIV, default 100000, clock cycles per display digit slot (1 ms).
REQ-003 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start_stop  input  1  one-cycle pulse, already debounced and synchronous to clk, toggles run/pause.
REQ-006 SHALL have port clear  input  1  one-cycle pulse, synchronous to clk, zeroes the time and returns to idle.
REQ-007 SHALL have port di  output  4  BCD value of the currently scanned digit, feeds the 7-segment decoder input.
REQ-008 SHALL have port an  output  4  digit enables, active-low one-hot, an[0] = rightmost digit.
REQ-009 SHALL have port dp  output  1  decimal point, active-low.
REQ-010 SHALL have port running  output  1  high while in state RUN.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse on rollover 59.99 -> 00.00.

Function
REQ-012 SHALL keep four BCD digit registers d3 d2 d1 d0 showing SS.cc: d0 and d1 range 0-9 (hundredths), d2 range 0-9 (seconds units), d3 range 0-5 (seconds tens).
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE: start_stop moves IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-014 SHALL make clear force IDLE from any state, zero all digits and zero the tick prescaler on the next edge.
REQ-015 SHALL give clear priority over start_stop when both are asserted in the same cycle (result IDLE, digits 0).
REQ-016 SHALL advance the tick prescaler only in RUN, counting 0..TICK_DIV-1, and hold its value in PAUSE so a resumed interval continues from where it stopped.
REQ-017 SHALL increment the time by one hundredth on the edge where state is RUN and prescaler equals TICK_DIV-1; on that same edge the prescaler SHALL return to 0.
REQ-018 SHALL carry as follows: d0 9->0 increments d1; d1 9->0 increments d2; d2 9->0 increments d3; d3 5->0 on full carry.
REQ-019 SHALL on 59.99 -> 00.00 assert wrap for exactly the one cycle following that edge and remain in RUN.
REQ-020 SHALL when start_stop coincides with a tick in RUN perform the increment and enter PAUSE on the same edge.
REQ-021 SHALL ignore start_stop in cycles where clear is asserted, and never increment in IDLE or PAUSE.
REQ-022 SHALL run a free-running scan prescaler 0..SCAN_DIV-1 in all states and advance a 2-bit select sel 0->1->2->3->0 when it reaches SCAN_DIV-1.
REQ-023 SHALL drive an combinationally from sel: sel 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111.
REQ-024 SHALL drive di combinationally from sel and the digit registers: sel 0 -> d0, 1 -> d1, 2 -> d2, 3 -> d3, so di and an always refer to the same digit.
REQ-025 SHALL drive dp = 0 only when sel = 2 (point after seconds units), otherwise 1.
REQ-026 SHALL drive running = 1 exactly when the FSM is in RUN.
REQ-027 SHALL never present a di value above 9, so the decoder blank codes are never selected.

Reset
REQ-028 SHALL on rst_n low immediately, without waiting for clk, set state IDLE, all digits 0, both prescalers 0 and sel 0, which gives an = 1110, di = 0, dp = 1, running = 0 and wrap = 0.
REQ-029 SHALL on rst_n low during RUN discard the partial tick count, and after release SHALL stay in IDLE until a start_stop pulse.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-030 SHALL cover basic counting: reset, start_stop pulse, 40 cycles -> d1d0 = 10, running = 1.
REQ-031 SHALL cover pause and resume: pause 2 cycles after a tick, hold 20 cycles, resume -> digits unchanged while paused, and the next increment comes exactly 2 cycles after resume.
REQ-032 SHALL cover rollover: run to 59.99, then one tick -> digits 00.00, wrap high for 1 cycle, still RUN.
REQ-033 SHALL cover priority: clear and start_stop in the same cycle while in RUN -> IDLE, digits 0, running = 0.
REQ-034 SHALL cover scanning: with digits 12.34, step through sel 0..3 -> (an, di, dp) = (1110, 4, 1), (1101, 3, 1), (1011, 2, 0), (0111, 1, 1), each held 2 cycles.
REQ-035 SHALL cover asynchronous reset: drop rst_n mid-cycle during RUN -> all outputs at reset values before the next clk edge.
